// File: rtl/sda_reg_bus_if.sv
// Purpose: one simple register-bus port (request/ack handshake with address, data, strobes).
// Latency: none, signal bundle only.
// Backpressure: requester holds req and its fields until it sees a one-cycle ack.
//
// Ports (modports):
//   master : drives req/write_en/addr/wdata/wstrb, receives ack/rdata
//   slave  : receives req/write_en/addr/wdata/wstrb, drives ack/rdata
interface sda_reg_bus_if #(
    parameter int RegAddrWidth = 8
);
    logic                    req;
    logic                    write_en;
    logic [RegAddrWidth-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    ack;
    logic [31:0]             rdata;

    modport master (
        output req,
        output write_en,
        output addr,
        output wdata,
        output wstrb,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  write_en,
        input  addr,
        input  wdata,
        input  wstrb,
        output ack,
        output rdata
    );
endinterface

// File: rtl/sda_reg_bus_arbiter.sv
// Purpose: round-robin share of one register slave between requester A (host) and B (debug).
// Latency: grant -> slave req 1 cycle; slave ack -> requester ack 1 cycle; >=1 idle slave cycle between transactions.
// Backpressure: one transaction in flight; the losing requester simply waits with req held.
//
// Ports:
//   clk, srst      : clock, synchronous active-high reset
//   i_a_bus        : requester A (slave modport of sda_reg_bus_if)
//   i_b_bus        : requester B (slave modport of sda_reg_bus_if)
//   o_reg_bus      : register slave (master modport of sda_reg_bus_if), all outputs registered
//   o_timeout_err  : sticky slave-timeout flag
// Optional feature: define SDA_REG_ARB_TIMEOUT_EN to enable the slave ack timeout
// (TimeoutCycles cycles in ISSUE without regAck completes the transaction with 32'hDEAD_BEEF).
module sda_reg_bus_arbiter #(
    parameter int RegAddrWidth  = 8,
    parameter int TimeoutCycles = 256
) (
    input  logic          clk,
    input  logic          srst,
    sda_reg_bus_if.slave  i_a_bus,
    sda_reg_bus_if.slave  i_b_bus,
    sda_reg_bus_if.master o_reg_bus,
    output logic          o_timeout_err
);

    // Elaboration-time guard: the timeout counter is 16 bits and needs at least 2 cycles.
    if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_bad_timeout_cycles
        $error("sda_reg_bus_arbiter: TimeoutCycles must be within 2..65535");
    end

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]              r_state;
    logic                    r_prio_b;     // 1: B has priority on contention
    logic                    r_winner_b;   // owner of the in-flight transaction
    logic                    r_reg_req;
    logic                    r_reg_we;
    logic [RegAddrWidth-1:0] r_reg_addr;
    logic [31:0]             r_reg_wdata;
    logic [3:0]              r_reg_wstrb;
    logic                    r_a_ack;
    logic                    r_b_ack;
    logic [31:0]             r_a_rdata;
    logic [31:0]             r_b_rdata;

    logic                    w_any_req;
    logic                    w_grant_b;
    logic                    w_done;
    logic [31:0]             w_done_data;

    assign w_any_req = i_a_bus.req | i_b_bus.req;
    // B wins when it is the only requester, or both request and B holds priority.
    assign w_grant_b = i_b_bus.req & (~i_a_bus.req | r_prio_b);

`ifdef SDA_REG_ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    logic [15:0] r_cnt;
    logic        r_timeout_err;
    logic        w_expire;

    // A real ack arriving on the expiry cycle takes precedence over the timeout.
    assign w_expire = (r_state == ST_ISSUE) && !o_reg_bus.ack && (r_cnt == TimeoutLast);
`endif

    always_comb begin
        w_done      = (r_state == ST_ISSUE) && o_reg_bus.ack;
        w_done_data = o_reg_bus.rdata;
`ifdef SDA_REG_ARB_TIMEOUT_EN
        if (w_expire) begin
            w_done      = 1'b1;
            w_done_data = 32'hDEAD_BEEF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= ST_IDLE;
            r_prio_b    <= 1'b0;
            r_winner_b  <= 1'b0;
            r_reg_req   <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wstrb <= '0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
`ifdef SDA_REG_ARB_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // Acks are single-cycle pulses and read data is zero outside them,
            // so both requester return paths can be OR-ed downstream.
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_winner_b  <= w_grant_b;
                        r_prio_b    <= ~w_grant_b;
                        r_reg_we    <= w_grant_b ? i_b_bus.write_en : i_a_bus.write_en;
                        r_reg_addr  <= w_grant_b ? i_b_bus.addr     : i_a_bus.addr;
                        r_reg_wdata <= w_grant_b ? i_b_bus.wdata    : i_a_bus.wdata;
                        r_reg_wstrb <= w_grant_b ? i_b_bus.wstrb    : i_a_bus.wstrb;
                        r_reg_req   <= 1'b1;
                        r_state     <= ST_ISSUE;
`ifdef SDA_REG_ARB_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (w_done) begin
                        r_reg_req <= 1'b0;
                        r_a_ack   <= ~r_winner_b;
                        r_b_ack   <= r_winner_b;
                        r_a_rdata <= r_winner_b ? 32'h0 : w_done_data;
                        r_b_rdata <= r_winner_b ? w_done_data : 32'h0;
                        r_state   <= ST_RELEASE;
                    end
`ifdef SDA_REG_ARB_TIMEOUT_EN
                    if (w_expire) begin
                        r_timeout_err <= 1'b1;
                    end else if (!w_done) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`endif
                end

                // Requests are not sampled here so the completed requester can drop req.
                ST_RELEASE: r_state <= ST_IDLE;

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_reg_bus.req      = r_reg_req;
    assign o_reg_bus.write_en = r_reg_we;
    assign o_reg_bus.addr     = r_reg_addr;
    assign o_reg_bus.wdata    = r_reg_wdata;
    assign o_reg_bus.wstrb    = r_reg_wstrb;

    assign i_a_bus.ack   = r_a_ack;
    assign i_a_bus.rdata = r_a_rdata;
    assign i_b_bus.ack   = r_b_ack;
    assign i_b_bus.rdata = r_b_rdata;

`ifdef SDA_REG_ARB_TIMEOUT_EN
    assign o_timeout_err = r_timeout_err;
`else
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sda_reg_bus_arbiter.sv
// Purpose: self-checking bench for sda_reg_bus_arbiter (directed scenarios then random traffic).
// Latency: expected outputs come from a transaction-level reference model updated every clock edge.
// Backpressure: bench plays both requesters and a slave with random ack latency.
module tb_sda_reg_bus_arbiter;
    localparam int AW = 8;
    localparam int TO = 8;
`ifdef SDA_REG_ARB_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic srst;
    logic timeout_err;
    always #5 clk = ~clk;

    sda_reg_bus_if #(.RegAddrWidth(AW)) a_bus ();
    sda_reg_bus_if #(.RegAddrWidth(AW)) b_bus ();
    sda_reg_bus_if #(.RegAddrWidth(AW)) reg_bus ();

    sda_reg_bus_arbiter #(.RegAddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clk           (clk),
        .srst          (srst),
        .i_a_bus       (a_bus),
        .i_b_bus       (b_bus),
        .o_reg_bus     (reg_bus),
        .o_timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: transaction in flight, edges to skip after completion, priority owner.
    bit          m_busy, m_win_b, m_ptr_b, m_to;
    int          m_wait, m_age;
    bit          e_req, e_aack, e_back, e_fields_zero;
    logic [31:0] e_ard, e_brd;
    bit          e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;

    // Slave responder state.
    int          s_cnt = -1;
    int          s_lat = -1;
    bit          s_silent = 1'b0;
    bit          s_spurious = 1'b0;
    bit          s_fix_en = 1'b0;
    logic [31:0] s_fix_data = '0;

    bit          prev_reg_req = 1'b0;
    bit          obs_grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic finish_txn(input logic [31:0] d);
        m_busy = 1'b0;
        m_wait = 1;
        e_req  = 1'b0;
        if (m_win_b) begin e_back = 1'b1; e_brd = d; end
        else         begin e_aack = 1'b1; e_ard = d; end
    endtask

    task automatic model_edge();
        if (srst) begin
            m_busy = 0; m_wait = 0; m_ptr_b = 0; m_to = 0; m_age = 0;
            e_req = 0; e_aack = 0; e_back = 0; e_ard = '0; e_brd = '0;
            e_fields_zero = 1'b1;
        end else begin
            e_aack = 0; e_back = 0; e_ard = '0; e_brd = '0;
            if (m_busy) begin
                if (reg_bus.ack) begin
                    finish_txn(reg_bus.rdata);
                end else begin
                    m_age++;
                    if (TimeoutOn && m_age == TO) begin
                        finish_txn(32'hDEAD_BEEF);
                        m_to = 1'b1;
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (a_bus.req || b_bus.req) begin
                m_win_b = b_bus.req && (!a_bus.req || m_ptr_b);
                m_ptr_b = !m_win_b;
                e_we    = m_win_b ? b_bus.write_en : a_bus.write_en;
                e_addr  = m_win_b ? b_bus.addr     : a_bus.addr;
                e_wdata = m_win_b ? b_bus.wdata    : a_bus.wdata;
                e_wstrb = m_win_b ? b_bus.wstrb    : a_bus.wstrb;
                e_req = 1'b1; m_busy = 1'b1; m_age = 0; e_fields_zero = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("reg_req", 32'(reg_bus.req), 32'(e_req));
        chk("a_ack", 32'(a_bus.ack), 32'(e_aack));
        chk("b_ack", 32'(b_bus.ack), 32'(e_back));
        chk("a_rdata", a_bus.rdata, e_ard);
        chk("b_rdata", b_bus.rdata, e_brd);
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        if (e_req) begin
            chk("reg_we", 32'(reg_bus.write_en), 32'(e_we));
            chk("reg_addr", 32'(reg_bus.addr), 32'(e_addr));
            chk("reg_wdata", reg_bus.wdata, e_wdata);
            chk("reg_wstrb", 32'(reg_bus.wstrb), 32'(e_wstrb));
        end else if (e_fields_zero) begin
            chk("rst_we", 32'(reg_bus.write_en), 32'h0);
            chk("rst_addr", 32'(reg_bus.addr), 32'h0);
            chk("rst_wdata", reg_bus.wdata, 32'h0);
            chk("rst_wstrb", 32'(reg_bus.wstrb), 32'h0);
        end
        if (reg_bus.req && !prev_reg_req) obs_grants.push_back(reg_bus.addr == b_bus.addr);
        prev_reg_req = reg_bus.req;
    endtask

    task automatic slave_drive();
        reg_bus.ack   = 1'b0;
        reg_bus.rdata = $urandom;
        if (srst) begin
            s_cnt = -1;
        end else if (s_spurious && !reg_bus.req) begin
            reg_bus.ack = 1'b1;
            s_spurious  = 1'b0;
        end else if (reg_bus.req && !s_silent) begin
            if (s_cnt < 0) s_cnt = (s_lat >= 0) ? s_lat : int'($urandom_range(0, 3));
            if (s_cnt == 0) begin
                reg_bus.ack = 1'b1;
                if (s_fix_en) reg_bus.rdata = s_fix_data;
                s_cnt = -1;
            end else begin
                s_cnt--;
            end
        end else begin
            s_cnt = -1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        slave_drive();
    endtask

    task automatic raise(input bit side_b, input bit we, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (side_b) begin
            b_bus.req = 1'b1; b_bus.write_en = we; b_bus.addr = addr; b_bus.wdata = wd; b_bus.wstrb = ws;
        end else begin
            a_bus.req = 1'b1; a_bus.write_en = we; a_bus.addr = addr; a_bus.wdata = wd; a_bus.wstrb = ws;
        end
    endtask

    task automatic run_until_ack(input bit side_b, input int max_cyc, output bit seen, output logic [31:0] d);
        seen = 1'b0;
        d    = '0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            cycle();
            if (side_b ? b_bus.ack : a_bus.ack) begin
                seen = 1'b1;
                d    = side_b ? b_bus.rdata : a_bus.rdata;
                if (side_b) b_bus.req = 1'b0; else a_bus.req = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int n);
        srst = 1'b1;
        a_bus.req = 1'b0;
        b_bus.req = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        srst = 1'b0;
    endtask

    task automatic rand_requester(input bit side_b);
        bit req = side_b ? b_bus.req : a_bus.req;
        bit ack = side_b ? b_bus.ack : a_bus.ack;
        if (req && ack) begin
            if (side_b) b_bus.req = 1'b0; else a_bus.req = 1'b0;
        end else if (req && $urandom_range(0, 15) == 0) begin
            if (side_b) b_bus.req = 1'b0; else a_bus.req = 1'b0;
        end else if (!req && $urandom_range(0, 3) == 0) begin
            raise(side_b, 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
        end
    endtask

    initial begin
        bit          seen;
        logic [31:0] d;

        srst = 1'b1;
        raise(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        raise(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
        a_bus.req = 1'b0;
        b_bus.req = 1'b0;
        reg_bus.ack = 1'b0;
        reg_bus.rdata = '0;
        do_reset(3);

        // 1: A read of 0x00, slave answers 2 cycles after regReq.
        s_lat = 2; s_fix_en = 1'b1; s_fix_data = 32'h0000_000C;
        raise(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        run_until_ack(1'b0, 20, seen, d);
        chk("t1_ack_seen", 32'(seen), 32'h1);
        chk("t1_rdata", d, 32'h0000_000C);
        s_fix_en = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // 2: A write of 0x1234_5678 to 0x10.
        raise(1'b0, 1'b1, 8'h10, 32'h1234_5678, 4'hF);
        cycle(); cycle();
        chk("t2_we", 32'(reg_bus.write_en), 32'h1);
        chk("t2_addr", 32'(reg_bus.addr), 32'h10);
        chk("t2_wdata", reg_bus.wdata, 32'h1234_5678);
        run_until_ack(1'b0, 20, seen, d);
        chk("t2_ack_seen", 32'(seen), 32'h1);
        for (int i = 0; i < 3; i++) cycle();

        // 3: continuous contention from reset alternates A, B, A.
        do_reset(2);
        s_lat = 1;
        obs_grants.delete();
        raise(1'b0, 1'b0, 8'h20, 32'h0, 4'h0);
        raise(1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
        for (int i = 0; i < 60 && obs_grants.size() < 3; i++) cycle();
        a_bus.req = 1'b0;
        b_bus.req = 1'b0;
        chk("t3_grant_cnt", 32'(obs_grants.size() >= 3), 32'h1);
        chk("t3_grant0", 32'(obs_grants[0]), 32'h0);
        chk("t3_grant1", 32'(obs_grants[1]), 32'h1);
        chk("t3_grant2", 32'(obs_grants[2]), 32'h0);
        for (int i = 0; i < 10; i++) cycle();

        // 4: spurious regAck while idle, then a normal B read.
        s_spurious = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        raise(1'b1, 1'b0, 8'h44, 32'h0, 4'h0);
        run_until_ack(1'b1, 20, seen, d);
        chk("t4_b_ack_seen", 32'(seen), 32'h1);
        for (int i = 0; i < 3; i++) cycle();

        // 5: reset while a transaction is stuck in ISSUE.
        s_silent = 1'b1;
        raise(1'b0, 1'b0, 8'h08, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_req_before", 32'(reg_bus.req), 32'h1);
        do_reset(1);
        chk("t5_req_after", 32'(reg_bus.req), 32'h0);
        for (int i = 0; i < 5; i++) cycle();
        s_silent = 1'b0;
        raise(1'b0, 1'b0, 8'h0C, 32'h0, 4'h0);
        run_until_ack(1'b0, 20, seen, d);
        chk("t5_next_ack_seen", 32'(seen), 32'h1);
        for (int i = 0; i < 3; i++) cycle();

`ifdef SDA_REG_ARB_TIMEOUT_EN
        // 6: silent slave -> timeout completion and sticky flag.
        s_silent = 1'b1;
        raise(1'b0, 1'b0, 8'h04, 32'h0, 4'h0);
        run_until_ack(1'b0, 30, seen, d);
        chk("t6_ack_seen", 32'(seen), 32'h1);
        chk("t6_rdata", d, 32'hDEAD_BEEF);
        s_silent = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("t6_err_sticky", 32'(timeout_err), 32'h1);
        do_reset(1);
        chk("t6_err_cleared", 32'(timeout_err), 32'h0);
`endif

        // Random traffic from both requesters against random slave latency.
        s_lat = -1;
        for (int i = 0; i < 500; i++) begin
            cycle();
            rand_requester(1'b0);
            rand_requester(1'b1);
            if (!reg_bus.req && $urandom_range(0, 15) == 0) s_spurious = 1'b1;
        end
        a_bus.req = 1'b0;
        b_bus.req = 1'b0;
        for (int i = 0; i < 15; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
